hypot_sched: RTL and testbench
==============================

HYPOT_SCHED -- requirements
Module: hypot_sched

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand width in bits.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: ena  input  1  global enable; low freezes all state.
REQ-005 SHALL have ports: req0_valid/req1_valid  input  1  request pending from requester 0/1.
REQ-006 SHALL have ports: req0_x, req0_y, req1_x, req1_y  input  WIDTH  unsigned operands.
REQ-007 SHALL have ports: req0_ready/req1_ready  output  1  accept strobe to requester 0/1.
REQ-008 SHALL have ports: rsp_valid  output  1; rsp_ready  input  1; rsp_id  output  1 (granted requester); rsp_mag  output  WIDTH+1  floor(sqrt(x^2+y^2)).
REQ-009 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, SQX, SQY, ROOT, DONE; one engine shared by both requesters.
REQ-011 In IDLE with ena=1: SHALL drive exactly one reqN_ready high, to the granted valid requester; both readies low otherwise. Readies are combinational from state, pointer and valids.
REQ-012 Accept = reqN_valid && reqN_ready on a rising edge; SHALL capture x, y, id; next state SQX.
REQ-013 SQX: W-cycle shift-add squaring of x; SQY: W-cycle squaring of y, accumulated into a (2*WIDTH+1)-bit sum; ROOT: WIDTH+1-cycle restoring bit-serial square root, MSB first.
REQ-014 SHALL assert rsp_valid exactly 3*WIDTH+1 enabled edges after the accepting edge (25 for WIDTH=8), entering DONE.
REQ-015 In DONE: rsp_valid, rsp_id and rsp_mag SHALL stay stable until rsp_ready=1; the handshake edge returns the FSM to IDLE.
REQ-016 SHALL NOT accept a request on the rsp handshake edge; minimum one IDLE cycle between jobs.
REQ-017 rsp_mag SHALL hold the last result outside DONE; rsp_valid SHALL be 0 outside DONE.
REQ-018 ena=0: SHALL hold FSM, counters, datapath and outputs; readies SHALL be 0; a pending rsp handshake SHALL be ignored.
REQ-019 Full-scale inputs (x=y=2^WIDTH-1) SHALL produce no overflow; result fits WIDTH+1 bits.
REQ-020 Requesters SHALL not be required to hold valid; a dropped valid before accept is not serviced.

Reset
REQ-021 rst_n low SHALL immediately force: state IDLE, rsp_valid 0, rsp_id 0, rsp_mag 0, busy 0, arbitration pointer favouring requester 0; an in-flight job is discarded.

Configuration
REQ-022 With HYPOT_RR_ARB_EN defined: round-robin grant; on simultaneous valid, the requester not served last wins; pointer updates on accept only.
REQ-023 Without HYPOT_RR_ARB_EN: fixed priority, requester 0 always wins; no pointer register exists.

Structure
REQ-024 Package hypot_pkg SHALL hold the FSM state enum, the default WIDTH constant and the requester-id type.
REQ-025 Sub-module hypot_engine SHALL hold the squaring/accumulate/root datapath and its cycle counter, driven by the FSM; hypot_sched holds arbitration, FSM and handshakes.

Verification
REQ-026 req0 x=3,y=4, rsp_ready=1 -> rsp_mag=5, rsp_id=0, rsp_valid exactly 25 cycles after accept.
REQ-027 req1 x=255,y=255 -> rsp_mag=360, rsp_id=1; x=0,y=0 -> rsp_mag=0.
REQ-028 both valid continuously, x=6,y=8 and x=5,y=12 -> with HYPOT_RR_ARB_EN ids alternate 0,1,0 (mags 10,13,10); without it ids are 0,0,0.
REQ-029 rsp_ready low 10 cycles in DONE -> rsp_valid, rsp_mag, rsp_id stable; both readies low; busy=1.
REQ-030 ena low 5 cycles during ROOT -> latency 30 cycles, same result, no state change while low.
REQ-031 rst_n pulsed during SQY -> outputs zero asynchronously; next job x=1,y=1 -> rsp_mag=1, id=0.

Source files
------------

// File: rtl/hypot_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hypot_pkg
// Brief    : Shared types and constants for the hypot_sched block.
// Revision : 1.0 - initial release
// ============================================================================
package hypot_pkg;

  localparam int unsigned c_default_width = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SQX  = 3'd1,
    ST_SQY  = 3'd2,
    ST_ROOT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  typedef logic req_id_t;

endpackage
`default_nettype wire

// File: rtl/hypot_engine.sv
`default_nettype none
// ============================================================================
// Module   : hypot_engine
// Brief    : Bit-serial x^2+y^2 accumulate and restoring square root datapath.
// Revision : 1.0 - initial release
// ============================================================================
module hypot_engine
  import hypot_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  state_t           state,
  output logic             last,
  output logic [WIDTH:0]   mag
);

  localparam int c_cw = $clog2(WIDTH + 1);
  localparam int c_sw = 2 * WIDTH + 1;
  // Remainder never exceeds 2*root, so WIDTH+2 bits suffice.
  localparam int c_rw = WIDTH + 2;
  localparam logic [c_cw-1:0] c_sq_last   = c_cw'(WIDTH - 1);
  localparam logic [c_cw-1:0] c_root_last = c_cw'(WIDTH);

  logic [c_cw-1:0]    r_cnt;
  logic [WIDTH-1:0]   r_mult;
  logic [WIDTH-1:0]   r_y;
  logic [2*WIDTH-1:0] r_mcand;
  logic [c_sw-1:0]    r_sum;
  logic [c_rw-1:0]    r_rem;
  logic [WIDTH:0]     r_root;
  logic [WIDTH:0]     r_mag;

  logic [c_sw-1:0]    w_sum_add;
  logic [1:0]         w_pair;
  logic [c_rw+1:0]    w_rem_sh;
  logic [c_rw+1:0]    w_trial;
  logic [c_rw+1:0]    w_diff;
  logic [c_rw-1:0]    w_rem_next;
  logic [WIDTH:0]     w_root_next;

  assign last      = (state == ST_ROOT) ? (r_cnt == c_root_last) : (r_cnt == c_sq_last);
  assign mag       = r_mag;
  assign w_sum_add = r_mult[0] ? r_sum + c_sw'(r_mcand) : r_sum;

  // The odd-width sum is consumed as a lone top bit first, then in pairs.
  always_comb begin
    w_pair   = (r_cnt == '0) ? {1'b0, r_sum[c_sw-1]} : r_sum[c_sw-1:c_sw-2];
    w_rem_sh = {r_rem, w_pair};
    w_trial  = (c_rw + 2)'({r_root, 2'b01});
    w_diff   = w_rem_sh - w_trial;
    if (w_rem_sh >= w_trial) begin
      w_rem_next  = c_rw'(w_diff);
      w_root_next = (WIDTH + 1)'({r_root, 1'b1});
    end else begin
      w_rem_next  = c_rw'(w_rem_sh);
      w_root_next = (WIDTH + 1)'({r_root, 1'b0});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_mult  <= '0;
      r_y     <= '0;
      r_mcand <= '0;
      r_sum   <= '0;
      r_rem   <= '0;
      r_root  <= '0;
      r_mag   <= '0;
    end else if (ena) begin
      if (start) begin
        r_cnt   <= '0;
        r_mult  <= x;
        r_mcand <= (2 * WIDTH)'(x);
        r_y     <= y;
        r_sum   <= '0;
        r_rem   <= '0;
        r_root  <= '0;
      end else begin
        case (state)
          ST_SQX, ST_SQY: begin
            r_sum <= w_sum_add;
            if (last) begin
              r_cnt   <= '0;
              r_mult  <= r_y;
              r_mcand <= (2 * WIDTH)'(r_y);
            end else begin
              r_cnt   <= r_cnt + c_cw'(1);
              r_mult  <= r_mult >> 1;
              r_mcand <= r_mcand << 1;
            end
          end
          ST_ROOT: begin
            r_rem  <= w_rem_next;
            r_root <= w_root_next;
            r_sum  <= (r_cnt == '0) ? (r_sum << 1) : (r_sum << 2);
            if (last) begin
              r_cnt <= '0;
              r_mag <= w_root_next;
            end else begin
              r_cnt <= r_cnt + c_cw'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hypot_sched.sv
`default_nettype none
// ============================================================================
// Module   : hypot_sched
// Brief    : Two-requester arbiter and FSM sharing one floor(sqrt(x^2+y^2)) engine.
// Config   : HYPOT_RR_ARB_EN - round-robin grant (default: requester 0 priority).
// Revision : 1.0 - initial release
// ============================================================================
module hypot_sched
  import hypot_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH:0]   rsp_mag,
  output logic             busy
);

  state_t  r_state;
  state_t  w_state_next;
  req_id_t r_id;
  req_id_t w_grant;
  logic    w_accept;
  logic    w_last;

`ifdef HYPOT_RR_ARB_EN
  req_id_t r_ptr;

  always_comb begin
    if (req0_valid && req1_valid) w_grant = r_ptr;
    else                          w_grant = req0_valid ? 1'b0 : 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_ptr <= 1'b0;
    else if (w_accept) r_ptr <= ~w_grant;
  end
`else
  assign w_grant = req0_valid ? 1'b0 : 1'b1;
`endif

  always_comb begin
    w_state_next = r_state;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ena) begin
          req0_ready = req0_valid && (w_grant == 1'b0);
          req1_ready = req1_valid && (w_grant == 1'b1);
        end
        w_accept = req0_ready || req1_ready;
        if (w_accept) w_state_next = ST_SQX;
      end
      ST_SQX:  if (w_last) w_state_next = ST_SQY;
      ST_SQY:  if (w_last) w_state_next = ST_ROOT;
      ST_ROOT: if (w_last) w_state_next = ST_DONE;
      ST_DONE: if (rsp_ready) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ena gates every state update, which also masks a pending rsp handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_id    <= 1'b0;
    end else if (ena) begin
      r_state <= w_state_next;
      if (w_accept) r_id <= req1_ready;
    end
  end

  assign rsp_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign rsp_id    = r_id;

  hypot_engine #(
    .WIDTH (WIDTH)
  ) u_engine (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .start (w_accept),
    .x     (req1_ready ? req1_x : req0_x),
    .y     (req1_ready ? req1_y : req0_y),
    .state (r_state),
    .last  (w_last),
    .mag   (rsp_mag)
  );

endmodule
`default_nettype wire

// File: tb/tb_hypot_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_hypot_sched
// Brief    : Directed bench for hypot_sched with a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hypot_sched;

  localparam int W   = 8;
  localparam int LAT = 3 * W + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ena = 1'b0;
  logic         req0_valid = 1'b0;
  logic         req1_valid = 1'b0;
  logic [W-1:0] req0_x = '0;
  logic [W-1:0] req0_y = '0;
  logic [W-1:0] req1_x = '0;
  logic [W-1:0] req1_y = '0;
  logic         rsp_ready = 1'b0;
  logic         req0_ready;
  logic         req1_ready;
  logic         rsp_valid;
  logic         rsp_id;
  logic [W:0]   rsp_mag;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  // Reference model: job phase, enabled-edge countdown, held result.
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  bit m_id = 1'b0;
  bit m_ptr = 1'b0;
  bit m_pend_id = 1'b0;
  int m_left = 0;
  int m_mag = 0;
  int m_pend_mag = 0;

  hypot_sched #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .req0_valid (req0_valid),
    .req0_x     (req0_x),
    .req0_y     (req0_y),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_x     (req1_x),
    .req1_y     (req1_y),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_mag    (rsp_mag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic int hyp(input int x, input int y);
    int r = 0;
    while ((r + 1) * (r + 1) <= x * x + y * y) r++;
    return r;
  endfunction

  function automatic bit grant_of(input bit v0, input bit v1, input bit ptr);
`ifdef HYPOT_RR_ARB_EN
    if (v0 && v1) return ptr;
`endif
    return v0 ? 1'b0 : 1'b1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_id   <= 1'b0;
      m_mag  <= 0;
      m_ptr  <= 1'b0;
      m_left <= 0;
    end else if (ena) begin
      if (!m_busy) begin
        if (req0_valid || req1_valid) begin
          m_busy     <= 1'b1;
          m_left     <= LAT;
          m_pend_id  <= grant_of(req0_valid, req1_valid, m_ptr);
          m_pend_mag <= grant_of(req0_valid, req1_valid, m_ptr) ? hyp(req1_x, req1_y)
                                                                : hyp(req0_x, req0_y);
          m_ptr      <= ~grant_of(req0_valid, req1_valid, m_ptr);
        end
      end else if (!m_done) begin
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_mag  <= m_pend_mag;
          m_id   <= m_pend_id;
        end
        m_left <= m_left - 1;
      end else if (rsp_ready) begin
        m_busy <= 1'b0;
        m_done <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("rsp_valid", rsp_valid, m_done);
      check("busy", busy, m_busy);
      check("req0_ready", req0_ready,
            ena && !m_busy && req0_valid && !grant_of(req0_valid, req1_valid, m_ptr));
      check("req1_ready", req1_ready,
            ena && !m_busy && req1_valid && grant_of(req0_valid, req1_valid, m_ptr));
      check("rsp_mag", rsp_mag, m_mag);
      if (m_done) check("rsp_id", rsp_id, m_id);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_req(input bit which, input int x, input int y);
    bit acc = 1'b0;
    if (which) begin
      req1_x = W'(x); req1_y = W'(y); req1_valid = 1'b1;
    end else begin
      req0_x = W'(x); req0_y = W'(y); req0_valid = 1'b1;
    end
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = which ? req1_ready : req0_ready;
      tick();
    end
    if (which) req1_valid = 1'b0;
    else       req0_valid = 1'b0;
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_rsp(output int lat, output int mag, output int id);
    lat = 0;
    while (!rsp_valid && lat < 200) begin
      tick();
      lat++;
    end
    if (!rsp_valid) check("rsp_timeout", 0, 1);
    mag = rsp_mag;
    id  = rsp_id;
  endtask

  task automatic job(input bit which, input int x, input int y, input int exp_mag, input string tag);
    int lat, mag, id;
    accept_req(which, x, y);
    wait_rsp(lat, mag, id);
    check({tag, "_mag"}, mag, exp_mag);
    check({tag, "_id"}, id, which);
    check({tag, "_lat"}, lat, LAT);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    int lat, mag, id;
    int exp_arb_id[3];
    int exp_arb_mag[3];
`ifdef HYPOT_RR_ARB_EN
    exp_arb_id  = '{0, 1, 0};
    exp_arb_mag = '{10, 13, 10};
`else
    exp_arb_id  = '{0, 0, 0};
    exp_arb_mag = '{10, 10, 10};
`endif
    rst_n = 1'b0;
    ena = 1'b1;
    rsp_ready = 1'b1;
    repeat (3) tick();
    check("reset_valid", rsp_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_mag", rsp_mag, 0);
    check("reset_id", rsp_id, 0);
    rst_n = 1'b1;
    cmp_on = 1'b1;
    tick();

    job(1'b0, 3, 4, 5, "j345");
    job(1'b1, 255, 255, 360, "jfull");
    job(1'b1, 0, 0, 0, "jzero");

    // Both requesters held valid for three back-to-back jobs.
    req0_x = 8'd6; req0_y = 8'd8; req1_x = 8'd5; req1_y = 8'd12;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_rsp(lat, mag, id);
      check($sformatf("arb%0d_id", k), id, exp_arb_id[k]);
      check($sformatf("arb%0d_mag", k), mag, exp_arb_mag[k]);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // Response back-pressure with another requester waiting.
    rsp_ready = 1'b0;
    accept_req(1'b0, 3, 4);
    wait_rsp(lat, mag, id);
    req1_x = 8'd1; req1_y = 8'd1; req1_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("stall_valid", rsp_valid, 1);
      check("stall_mag", rsp_mag, 5);
      check("stall_id", rsp_id, 0);
      check("stall_rdy", {req0_ready, req1_ready}, 0);
      check("stall_busy", busy, 1);
      tick();
    end
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    check("stall_release", rsp_valid, 0);

    // Enable dropped for five cycles while in ROOT, then over a pending handshake.
    rsp_ready = 1'b0;
    accept_req(1'b1, 6, 8);
    repeat (18) tick();
    ena = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("frz_busy", busy, 1);
      check("frz_valid", rsp_valid, 0);
      tick();
    end
    ena = 1'b1;
    wait_rsp(lat, mag, id);
    check("ena_lat", 18 + 5 + lat, 30);
    check("ena_mag", mag, 10);
    check("ena_id", id, 1);
    ena = 1'b0;
    rsp_ready = 1'b1;
    tick();
    tick();
    check("ena_hold_valid", rsp_valid, 1);
    ena = 1'b1;
    tick();
    check("ena_release", rsp_valid, 0);

    // Idle with enable low: no ready even with a valid request.
    ena = 1'b0;
    req1_x = 8'd9; req1_y = 8'd9; req1_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_frz_rdy", req1_ready, 0);
      check("idle_frz_busy", busy, 0);
      tick();
    end
    ena = 1'b1;
    accept_req(1'b1, 9, 9);
    repeat (12) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_mag", rsp_mag, 0);
    check("arst_busy", busy, 0);
    check("arst_valid", rsp_valid, 0);
    check("arst_id", rsp_id, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    req1_x = 8'd1; req1_y = 8'd1; req1_valid = 1'b1;
    accept_req(1'b0, 1, 1);
    req1_valid = 1'b0;
    wait_rsp(lat, mag, id);
    check("post_rst_mag", mag, 1);
    check("post_rst_id", id, 0);
    check("post_rst_lat", lat, LAT);
    tick();
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
